hilo_div_ctrl: RTL and testbench
================================

// Module: hilo_div_ctrl
// PURPOSE
// EX-stage sequencer between the decoded instruction stream and the DIV/DIVU dividers.
// Launches signed or unsigned divides and stalls the pipeline while the divider runs.
// Captures the quotient into LO and the remainder into HI.
// Also owns the HI/LO registers for MTHI, MTLO, MFHI and MFLO.
// PARAMETERS
// W        32  operand / HI / LO width
// TIMEOUT  40  cycles in RUN before the watchdog fires (must be > 33)
// PORTS
// clk         in   1  clock, rising edge
// rst         in   1  reset, synchronous, active-low
// op_div      in   1  signed divide issued in EX this cycle
// op_divu     in   1  unsigned divide issued in EX this cycle
// op_mthi     in   1  write rs_val to HI
// op_mtlo     in   1  write rs_val to LO
// op_mfhi     in   1  read HI onto mf_data
// op_mflo     in   1  read LO onto mf_data
// flush       in   1  EX flush; abandons an in-flight divide
// rs_val      in   W  dividend / MT source
// rt_val      in   W  divisor
// dv_q,dv_r   in   W  quotient and remainder from DIV
// dv_busy     in   1  busy from DIV
// du_q,du_r   in   W  quotient and remainder from DIVU
// du_busy     in   1  busy from DIVU
// div_a,div_b out  W  latched operands to both dividers
// dv_start    out  1  one-cycle start pulse to DIV
// du_start    out  1  one-cycle start pulse to DIVU
// hi,lo       out  W  architectural HI/LO
// mf_data     out  W  op_mfhi ? hi : lo (combinational)
// stall       out  1  freeze IF/ID/EX
// div0        out  1  one-cycle pulse: divide by zero detected
// wdog_err    out  1  sticky; cleared only by reset
// BEHAVIOUR
// - Reset (rst==0 at posedge): state=IDLE; hi, lo, div_a, div_b = 0; starts, div0, wdog_err = 0.
// - Dividers share clk; their reset is driven with ~rst.
// - States: IDLE, LAUNCH, RUN, DRAIN. sel latches the unit in use (0=DIV, 1=DIVU).
// - IDLE + (op_div|op_divu) with rt_val!=0:
//   - Latch div_a/div_b and set sel.
//   - Pulse the matching start for exactly 1 cycle (registered, asserted in LAUNCH).
//   - Go to LAUNCH.
// - IDLE + divide with rt_val==0: no launch; HI/LO unchanged; div0=1 next cycle; stay IDLE.
// - LAUNCH: start high for one cycle -> RUN unconditionally (busy rises at that edge).
// - RUN with selected busy==1: wait and count cycles.
// - RUN with selected busy==0 (result final):
//   - Capture at this edge: lo<=q, hi<=r of the selected unit.
//   - Go to IDLE.
// - Timing: issue at edge N; LAUNCH N+1; RUN N+2..N+33; capture edge N+34.
// - stall: combinationally 1 on the issue cycle and while in LAUNCH or RUN.
// - stall: 0 in IDLE otherwise.
// - stall in DRAIN: 1 only if any op_* is present; otherwise 0.
// - flush in LAUNCH/RUN -> DRAIN; the result is discarded and HI/LO are untouched.
// - DRAIN exits to IDLE when the selected busy==0 after LAUNCH has completed.
// - flush in IDLE: drops the current op (no launch, no MT write).
// - MTHI/MTLO: write on the edge in IDLE when not stalled.
//   - In other states, MTHI/MTLO are held off by stall and retried.
// - MFHI/MFLO while LAUNCH/RUN: stall=1 (interlock); mf_data is valid once stall drops.
// - MT and capture never coincide: capture only occurs in RUN, and MT only in IDLE.
// - Watchdog: RUN or DRAIN for more than TIMEOUT cycles sets wdog_err and forces IDLE.
//   - A watchdog exit drops stall and leaves HI/LO unchanged.
// - Reset mid-divide: all state is cleared, the result is lost, and no start is emitted.
// - The divider is sign-correct, so results are latched as delivered with no post-fix.
// TESTING
// - DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 34 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; stall high 34 cycles.
// - DIVU rs=0xFFFFFFFF, rt=0x10 -> lo=0x0FFFFFFF, hi=0xF; dv_start never asserted.
// - DIV rt=0 with hi=0x11, lo=0x22 preset -> div0 pulse, no start pulse, hi/lo unchanged, stall 1 cycle.
// - MFLO issued the cycle after a DIV 100/7 launch -> stall until capture, then mf_data=14; a following MFHI gives 2.
// - flush during RUN of DIV 9/3 -> stall drops next cycle; hi/lo unchanged; a new DIVU stalls until DRAIN exits.
// - rst=0 at RUN cycle 10 -> hi=lo=0, IDLE, stall=0 next cycle; MTHI 0xABCD then MFHI returns 0xABCD.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: EX-stage sequencer for the DIV/DIVU dividers; also owns the HI/LO registers.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-low reset
//   op_div, op_divu     signed / unsigned divide issued in EX
//   op_mthi, op_mtlo    write rs_val to HI / LO
//   op_mfhi, op_mflo    read HI / LO onto mf_data
//   flush               EX flush; abandons an in-flight divide
//   rs_val, rt_val      dividend (or MT source) and divisor
//   dv_q/dv_r/dv_busy   result and busy from the signed divider
//   du_q/du_r/du_busy   result and busy from the unsigned divider
//   div_a, div_b        latched operands to both dividers
//   dv_start, du_start  one-cycle start pulses
//   hi, lo              architectural HI/LO
//   mf_data             HI or LO for MFHI/MFLO
//   stall               freeze IF/ID/EX
//   div0                one-cycle divide-by-zero pulse
//   wdog_err            sticky watchdog error, cleared only by reset
module hilo_div_ctrl #(
   parameter int W       = 32,
   parameter int TIMEOUT = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         op_div,
   input  logic         op_divu,
   input  logic         op_mthi,
   input  logic         op_mtlo,
   input  logic         op_mfhi,
   input  logic         op_mflo,
   input  logic         flush,
   input  logic [W-1:0] rs_val,
   input  logic [W-1:0] rt_val,
   input  logic [W-1:0] dv_q,
   input  logic [W-1:0] dv_r,
   input  logic         dv_busy,
   input  logic [W-1:0] du_q,
   input  logic [W-1:0] du_r,
   input  logic         du_busy,
   output logic [W-1:0] div_a,
   output logic [W-1:0] div_b,
   output logic         dv_start,
   output logic         du_start,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic [W-1:0] mf_data,
   output logic         stall,
   output logic         div0,
   output logic         wdog_err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DRAIN} state_t;
   state_t        state, state_n;
   logic          sel;
   logic [CW-1:0] wcnt;
   logic          is_div, any_op, idle_go, launch, zero_div, mt_ok, busy_sel, wdog_hit, capture;

   assign mf_data = op_mfhi ? hi : lo;

   always_comb begin
      is_div   = op_div | op_divu;
      any_op   = is_div | op_mthi | op_mtlo | op_mfhi | op_mflo;
      busy_sel = sel ? du_busy : dv_busy;
      idle_go  = (state == IDLE) && !flush;
      launch   = idle_go && is_div && (rt_val != '0);
      zero_div = idle_go && is_div && (rt_val == '0);
      mt_ok    = idle_go && !is_div;
      wdog_hit = ((state == RUN) || (state == DRAIN)) && (wcnt == CW'(TIMEOUT));
      capture  = (state == RUN) && !flush && !busy_sel && !wdog_hit;
      state_n  = state;
      stall    = 1'b0;
      case (state)
         IDLE: begin
            stall   = idle_go && is_div;
            state_n = launch ? LAUNCH : IDLE;
         end
         LAUNCH: begin
            stall   = 1'b1;
            state_n = flush ? DRAIN : RUN;
         end
         RUN: begin
            stall   = 1'b1;
            state_n = flush ? DRAIN : (busy_sel ? RUN : IDLE);
         end
         default: begin
            stall   = any_op;
            state_n = busy_sel ? DRAIN : IDLE;
         end
      endcase
      // a hung divider must not freeze the pipeline forever
      if (wdog_hit) begin
         state_n = IDLE;
         stall   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         sel      <= 1'b0;
         wcnt     <= '0;
         div_a    <= '0;
         div_b    <= '0;
         dv_start <= 1'b0;
         du_start <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         div0     <= 1'b0;
         wdog_err <= 1'b0;
      end else begin
         state    <= state_n;
         dv_start <= launch && op_div;
         du_start <= launch && !op_div;
         div0     <= zero_div;
         wcnt     <= ((state == RUN) || (state == DRAIN)) ? wcnt + 1'b1 : '0;
         if (wdog_hit) wdog_err <= 1'b1;
         if (launch) begin
            div_a <= rs_val;
            div_b <= rt_val;
            sel   <= !op_div;
         end
         // dividers deliver sign-correct results, latched as-is
         if (capture) begin
            lo <= sel ? du_q : dv_q;
            hi <= sel ? du_r : dv_r;
         end
         if (mt_ok && op_mthi) hi <= rs_val;
         if (mt_ok && op_mtlo) lo <= rs_val;
      end
   end
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: self-checking bench for hilo_div_ctrl with behavioural divider models.
module tb_hilo_div_ctrl;
   localparam int W = 32;
   logic clk = 1'b0, rst = 1'b0;
   logic op_div = 1'b0, op_divu = 1'b0, op_mthi = 1'b0, op_mtlo = 1'b0;
   logic op_mfhi = 1'b0, op_mflo = 1'b0, flush = 1'b0;
   logic [W-1:0] rs_val = '0, rt_val = '0;
   logic [W-1:0] dv_q, dv_r, du_q, du_r, div_a, div_b, hi, lo, mf_data;
   logic dv_busy, du_busy, dv_start, du_start, stall, div0, wdog_err;
   logic hang = 1'b0;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   // divider models: busy for 31 cycles after start, result valid only once idle
   logic [5:0] dv_cnt = '0, du_cnt = '0;
   logic [W-1:0] dv_qr = '0, dv_rr = '0, du_qr = '0, du_rr = '0;
   assign dv_busy = dv_cnt != 0;
   assign du_busy = du_cnt != 0;
   assign dv_q = dv_busy ? 32'hDEADBEEF : dv_qr;
   assign dv_r = dv_busy ? 32'hDEADBEEF : dv_rr;
   assign du_q = du_busy ? 32'hDEADBEEF : du_qr;
   assign du_r = du_busy ? 32'hDEADBEEF : du_rr;
   always @(posedge clk) begin
      if (!rst) begin
         dv_cnt <= '0;
         du_cnt <= '0;
      end else begin
         if (dv_start) begin
            dv_cnt <= 6'd31;
            dv_qr  <= W'($signed(div_a) / $signed(div_b));
            dv_rr  <= W'($signed(div_a) % $signed(div_b));
         end else if (dv_busy && !hang) dv_cnt <= dv_cnt - 1'b1;
         if (du_start) begin
            du_cnt <= 6'd31;
            du_qr  <= div_a / div_b;
            du_rr  <= div_a % div_b;
         end else if (du_busy && !hang) du_cnt <= du_cnt - 1'b1;
      end
   end

   hilo_div_ctrl #(.W(W), .TIMEOUT(40)) dut (
      .clk(clk), .rst(rst), .op_div(op_div), .op_divu(op_divu), .op_mthi(op_mthi),
      .op_mtlo(op_mtlo), .op_mfhi(op_mfhi), .op_mflo(op_mflo), .flush(flush),
      .rs_val(rs_val), .rt_val(rt_val), .dv_q(dv_q), .dv_r(dv_r), .dv_busy(dv_busy),
      .du_q(du_q), .du_r(du_r), .du_busy(du_busy), .div_a(div_a), .div_b(div_b),
      .dv_start(dv_start), .du_start(du_start), .hi(hi), .lo(lo), .mf_data(mf_data),
      .stall(stall), .div0(div0), .wdog_err(wdog_err));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mt(input bit h, input logic [W-1:0] v);
      op_mthi = h;
      op_mtlo = !h;
      rs_val  = v;
      tick();
      op_mthi = 1'b0;
      op_mtlo = 1'b0;
   endtask

   // holds the divide in EX until the controller accepts it; counts stalled cycles
   task automatic run_div(input bit u, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int n, output bit sdv, output bit sdu, output bit sz);
      n = 0; sdv = 0; sdu = 0; sz = 0;
      op_div = !u; op_divu = u; rs_val = a; rt_val = b;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (!stall) break;
         n++;
         tick();
         sdv |= dv_start; sdu |= du_start; sz |= div0;
         if (dv_start | du_start | div0) begin op_div = 0; op_divu = 0; end
      end
      op_div = 0; op_divu = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      total++; if (hi !== '0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
      total++; if (lo !== '0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
      total++; if ({div_a, div_b} !== '0) begin bad++; $display("FAIL reset_ops got=%h exp=0", {div_a, div_b}); end
      total++; if ({dv_start, du_start, div0, wdog_err, stall} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {dv_start, du_start, div0, wdog_err, stall}); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_div_signed();
      int n; bit sdv, sdu, sz;
      run_div(0, 32'hFFFFFFF9, 32'd2, n, sdv, sdu, sz);
      total++; if (n !== 34) begin bad++; $display("FAIL div_stall_cycles got=%0d exp=34", n); end
      total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
      total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
      total++; if ({sdv, sdu, sz} !== 3'b100) begin bad++; $display("FAIL div_pulses got=%b exp=100", {sdv, sdu, sz}); end
   endtask

   task automatic test_divu();
      int n; bit sdv, sdu, sz;
      run_div(1, 32'hFFFFFFFF, 32'h10, n, sdv, sdu, sz);
      total++; if (n !== 34) begin bad++; $display("FAIL divu_stall_cycles got=%0d exp=34", n); end
      total++; if (lo !== 32'h0FFFFFFF) begin bad++; $display("FAIL divu_lo got=%h exp=0fffffff", lo); end
      total++; if (hi !== 32'hF) begin bad++; $display("FAIL divu_hi got=%h exp=f", hi); end
      total++; if ({sdv, sdu, sz} !== 3'b010) begin bad++; $display("FAIL divu_pulses got=%b exp=010", {sdv, sdu, sz}); end
   endtask

   task automatic test_div0();
      int n; bit sdv, sdu, sz;
      mt(1, 32'h11);
      mt(0, 32'h22);
      run_div(0, 32'd5, 32'd0, n, sdv, sdu, sz);
      total++; if (n !== 1) begin bad++; $display("FAIL div0_stall_cycles got=%0d exp=1", n); end
      total++; if ({sdv, sdu, sz} !== 3'b001) begin bad++; $display("FAIL div0_pulses got=%b exp=001", {sdv, sdu, sz}); end
      total++; if ({hi, lo} !== {32'h11, 32'h22}) begin bad++; $display("FAIL div0_hilo got=%h exp=%h", {hi, lo}, {32'h11, 32'h22}); end
      tick();
      total++; if (div0 !== 1'b0) begin bad++; $display("FAIL div0_pulse_width got=%b exp=0", div0); end
   endtask

   task automatic test_mf_interlock();
      int n = 0;
      op_div = 1; rs_val = 32'd100; rt_val = 32'd7;
      tick();
      op_div = 0; op_mflo = 1;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (!stall) break;
         n++;
         tick();
      end
      total++; if (n !== 33) begin bad++; $display("FAIL mflo_interlock_cycles got=%0d exp=33", n); end
      total++; if (mf_data !== 32'd14) begin bad++; $display("FAIL mflo_data got=%h exp=e", mf_data); end
      op_mflo = 0; op_mfhi = 1;
      #1;
      total++; if (mf_data !== 32'd2) begin bad++; $display("FAIL mfhi_data got=%h exp=2", mf_data); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL mfhi_stall got=%b exp=0", stall); end
      op_mfhi = 0;
   endtask

   task automatic test_flush();
      int n, c; bit sdv, sdu, sz;
      mt(1, 32'h55);
      mt(0, 32'h66);
      op_div = 1; rs_val = 32'd9; rt_val = 32'd3;
      tick();
      op_div = 0;
      repeat (5) tick();
      flush = 1;
      tick();
      flush = 0;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
      total++; if ({hi, lo} !== {32'h55, 32'h66}) begin bad++; $display("FAIL flush_hilo got=%h exp=%h", {hi, lo}, {32'h55, 32'h66}); end
      c = int'(dv_cnt);
      run_div(1, 32'd50, 32'd8, n, sdv, sdu, sz);
      total++; if (n !== c + 35) begin bad++; $display("FAIL flush_drain_cycles got=%0d exp=%0d", n, c + 35); end
      total++; if ({hi, lo} !== {32'd2, 32'd6}) begin bad++; $display("FAIL flush_divu_hilo got=%h exp=%h", {hi, lo}, {32'd2, 32'd6}); end
   endtask

   task automatic test_random();
      int n; bit sdv, sdu, sz, u;
      logic [W-1:0] a, b, m_hi, m_lo;
      m_hi = $urandom; m_lo = $urandom;
      mt(1, m_hi);
      mt(0, m_lo);
      for (int k = 0; k < 16; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            a = $urandom;
            u = 1'($urandom_range(0, 1));
            mt(u, a);
            if (u) m_hi = a; else m_lo = a;
         end
         u = 1'($urandom_range(0, 1));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? '0 : ($urandom_range(0, 1) != 0 ? W'($urandom_range(1, 20)) : W'($urandom));
         if (!u && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
         run_div(u, a, b, n, sdv, sdu, sz);
         if (b != 0) begin
            if (u) begin m_lo = a / b; m_hi = a % b; end
            else begin m_lo = W'($signed(a) / $signed(b)); m_hi = W'($signed(a) % $signed(b)); end
         end
         total++; if (n !== (b == 0 ? 1 : 34)) begin bad++; $display("FAIL rnd_stall_cycles k=%0d got=%0d exp=%0d", k, n, b == 0 ? 1 : 34); end
         total++; if ({sdv, sdu, sz} !== (b == 0 ? 3'b001 : {!u, u, 1'b0})) begin bad++; $display("FAIL rnd_pulses k=%0d got=%b", k, {sdv, sdu, sz}); end
         total++; if ({hi, lo} !== {m_hi, m_lo}) begin bad++; $display("FAIL rnd_hilo k=%0d a=%h b=%h u=%b got=%h exp=%h", k, a, b, u, {hi, lo}, {m_hi, m_lo}); end
      end
   endtask

   task automatic test_watchdog();
      int n; bit sdv, sdu, sz;
      mt(1, 32'h1234);
      mt(0, 32'h5678);
      hang = 1;
      run_div(0, 32'd100, 32'd3, n, sdv, sdu, sz);
      total++; if (n !== 42) begin bad++; $display("FAIL wdog_stall_cycles got=%0d exp=42", n); end
      tick();
      total++; if (wdog_err !== 1'b1) begin bad++; $display("FAIL wdog_err got=%b exp=1", wdog_err); end
      total++; if ({hi, lo} !== {32'h1234, 32'h5678}) begin bad++; $display("FAIL wdog_hilo got=%h exp=%h", {hi, lo}, {32'h1234, 32'h5678}); end
      hang = 0;
      repeat (40) tick();
      total++; if (wdog_err !== 1'b1) begin bad++; $display("FAIL wdog_sticky got=%b exp=1", wdog_err); end
      rst = 0;
      tick();
      rst = 1;
      total++; if (wdog_err !== 1'b0) begin bad++; $display("FAIL wdog_reset got=%b exp=0", wdog_err); end
      tick();
   endtask

   task automatic test_reset_mid();
      bit st = 0;
      mt(1, 32'h77);
      mt(0, 32'h88);
      op_div = 1; rs_val = 32'd40; rt_val = 32'd5;
      tick();
      op_div = 0;
      repeat (10) tick();
      rst = 0;
      tick();
      rst = 1;
      total++; if ({hi, lo} !== '0) begin bad++; $display("FAIL rstmid_hilo got=%h exp=0", {hi, lo}); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
      repeat (40) begin
         st |= dv_start | du_start;
         tick();
      end
      total++; if (st !== 1'b0) begin bad++; $display("FAIL rstmid_start got=%b exp=0", st); end
      mt(1, 32'hABCD);
      op_mfhi = 1;
      #1;
      total++; if (mf_data !== 32'hABCD) begin bad++; $display("FAIL rstmid_mfhi got=%h exp=abcd", mf_data); end
      op_mfhi = 0;
   endtask

   initial begin
      test_reset();
      test_div_signed();
      test_divu();
      test_div0();
      test_mf_interlock();
      test_flush();
      test_random();
      test_watchdog();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
